// File: rtl/fxp_sqrt_pkg.sv
// Shared sizing helpers for the streaming fixed-point square root.
// Root width and pipeline depth both follow from the input integer and output fraction widths.
package fxp_sqrt_pkg;

  function automatic int root_int_bits(input int wii);
    return wii / 2;
  endfunction

  // One extra bit below the output LSB acts as the rounding guard.
  function automatic int root_bits(input int wii, input int wof);
    return root_int_bits(wii) + wof + 1;
  endfunction

  function automatic int rem_bits(input int wii, input int wof);
    return 2 * root_bits(wii, wof);
  endfunction

  function automatic int pipe_latency(input int wii, input int wof);
    return root_bits(wii, wof) + 2;
  endfunction

endpackage

// File: rtl/fxp_sqrt_stream_if.sv
// Valid/ready stream bundle for the fixed-point square root: radicand in, root out.
// master is the producer/consumer side, slave is the sqrt block.
interface fxp_sqrt_stream_if #(
  parameter int WII  = 9,
  parameter int WIF  = 10,
  parameter int WOI  = 9,
  parameter int WOF  = 10,
  parameter int TAGW = 4
);
  logic                 i_valid;
  logic                 i_ready;
  logic [WII+WIF-1:0]   i_data;
  logic [TAGW-1:0]      i_tag;
  logic                 o_valid;
  logic                 o_ready;
  logic [WOI+WOF-1:0]   o_data;
  logic [TAGW-1:0]      o_tag;
  logic                 o_neg;
  logic                 o_overflow;

  modport master (
    output i_valid, i_data, i_tag, o_ready,
    input  i_ready, o_valid, o_data, o_tag, o_neg, o_overflow
  );

  modport slave (
    input  i_valid, i_data, i_tag, o_ready,
    output i_ready, o_valid, o_data, o_tag, o_neg, o_overflow
  );
endinterface

// File: rtl/fxp_sqrt_stage.sv
// One restoring square-root iteration: resolves root bit BIT and keeps remainder = radicand - root^2.
// Valid is reset; the payload registers are not, since a cleared valid masks them.
module fxp_sqrt_stage #(
  parameter int RB   = 15,
  parameter int BIT  = 0,
  parameter int TAGW = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            adv,
  input  logic            in_valid,
  input  logic [2*RB-1:0] in_rem,
  input  logic [RB-1:0]   in_root,
  input  logic [TAGW-1:0] in_tag,
  input  logic            in_neg,
  output logic            out_valid,
  output logic [2*RB-1:0] out_rem,
  output logic [RB-1:0]   out_root,
  output logic [TAGW-1:0] out_tag,
  output logic            out_neg
);
  localparam int RW = 2 * RB;
  localparam int TW = RW + 1;

  logic [TW-1:0] trial;
  logic [TW-1:0] rem_x;
  logic          take;

  // (root + 2^BIT)^2 - root^2 = root*2^(BIT+1) + 2^(2*BIT)
  always_comb begin
    trial = (TW'(in_root) << (BIT + 1)) | (TW'(1) << (2 * BIT));
    rem_x = {1'b0, in_rem};
    take  = (rem_x >= trial);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
    end else if (adv) begin
      out_valid <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      out_rem  <= take ? RW'(rem_x - trial) : in_rem;
      out_root <= take ? (in_root | (RB'(1) << BIT)) : in_root;
      out_tag  <= in_tag;
      out_neg  <= in_neg;
    end
  end

endmodule

// File: rtl/fxp_sqrt_stream.sv
// Fully pipelined fixed-point square root with valid/ready, tag sideband, negative flag and saturation.
// A single stage-enable (adv) moves or freezes the whole pipeline, so bubbles are kept as-is.
module fxp_sqrt_stream
  import fxp_sqrt_pkg::*;
#(
  parameter int WII   = 9,
  parameter int WIF   = 10,
  parameter int WOI   = 9,
  parameter int WOF   = 10,
  parameter int ROUND = 1,
  parameter int TAGW  = 4
) (
  input logic              clk,
  input logic              rstn,
  fxp_sqrt_stream_if.slave bus
);
  localparam int RB  = root_bits(WII, WOF);
  localparam int RW  = rem_bits(WII, WOF);
  localparam int DW  = WII + WIF;
  localparam int OW  = WOI + WOF;
  localparam int FA  = 2 * (WOF + 1);
  localparam int SHL = (FA > WIF) ? FA - WIF : 0;
  localparam int SHR = (WIF > FA) ? WIF - FA : 0;
  localparam int WW  = RW + DW + SHL;
  localparam int CW  = ((RB > OW) ? RB : OW) + 1;
  localparam logic [CW-1:0] MAXV = {{(CW-OW+1){1'b0}}, {(OW-1){1'b1}}};

  typedef struct packed {
    logic [RW-1:0]   rem;
    logic [RB-1:0]   root;
    logic [TAGW-1:0] tag;
    logic            neg;
    logic            valid;
  } pl_t;

  logic            adv;
  logic            neg_in;
  logic [RW-1:0]   aligned;
  logic            s0_valid;
  logic [RW-1:0]   s0_rem;
  logic [TAGW-1:0] s0_tag;
  logic            s0_neg;
  pl_t             pl [RB+1];
  logic [CW-1:0]   rnd;
  logic            ovf_c;
  logic [OW-1:0]   data_c;
  logic            unused_rem;

  assign adv         = !bus.o_valid || bus.o_ready;
  assign bus.i_ready = adv;

  // Realign the radicand to 2*(WOF+1) fraction bits; a negative sample enters as zero.
  always_comb begin
    neg_in  = bus.i_data[DW-1];
    aligned = neg_in ? '0 : RW'((WW'(bus.i_data) << SHL) >> SHR);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s0_valid <= 1'b0;
    end else if (adv) begin
      s0_valid <= bus.i_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      s0_rem <= aligned;
      s0_tag <= bus.i_tag;
      s0_neg <= neg_in;
    end
  end

  assign pl[0] = '{rem: s0_rem, root: '0, tag: s0_tag, neg: s0_neg, valid: s0_valid};

  for (genvar i = 1; i <= RB; i++) begin : g_stage
    logic            st_valid;
    logic [RW-1:0]   st_rem;
    logic [RB-1:0]   st_root;
    logic [TAGW-1:0] st_tag;
    logic            st_neg;

    fxp_sqrt_stage #(
      .RB   (RB),
      .BIT  (RB - i),
      .TAGW (TAGW)
    ) u_stage (
      .clk       (clk),
      .rstn      (rstn),
      .adv       (adv),
      .in_valid  (pl[i-1].valid),
      .in_rem    (pl[i-1].rem),
      .in_root   (pl[i-1].root),
      .in_tag    (pl[i-1].tag),
      .in_neg    (pl[i-1].neg),
      .out_valid (st_valid),
      .out_rem   (st_rem),
      .out_root  (st_root),
      .out_tag   (st_tag),
      .out_neg   (st_neg)
    );

    assign pl[i] = '{rem: st_rem, root: st_root, tag: st_tag, neg: st_neg, valid: st_valid};
  end

  // The final remainder would only tell whether the root is exact, which the output does not report.
  assign unused_rem = ^pl[RB].rem;

  // Drop the guard bit (optionally rounding on it), then saturate; a rounding carry is caught too.
  always_comb begin
    rnd    = CW'(pl[RB].root >> 1) + ((ROUND != 0) ? CW'(pl[RB].root[0]) : '0);
    ovf_c  = !pl[RB].neg && (rnd > MAXV);
    data_c = pl[RB].neg ? '0 : (ovf_c ? OW'(MAXV) : OW'(rnd));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.o_valid    <= 1'b0;
      bus.o_data     <= '0;
      bus.o_tag      <= '0;
      bus.o_neg      <= 1'b0;
      bus.o_overflow <= 1'b0;
    end else if (adv) begin
      bus.o_valid <= pl[RB].valid;
      if (pl[RB].valid) begin
        bus.o_data     <= data_c;
        bus.o_tag      <= pl[RB].tag;
        bus.o_neg      <= pl[RB].neg;
        bus.o_overflow <= ovf_c;
      end
    end
  end

endmodule

// File: tb/tb_fxp_sqrt_stream.sv
// Bench for fxp_sqrt_stream: three instances (default, truncating, 3-bit output integer) share one stimulus
// stream and are each checked against an integer-square-root reference model.
module tb_fxp_sqrt_stream;
  localparam int DW   = 19;
  localparam int TAGW = 4;
  localparam int WOF  = 10;
  localparam int LAT  = 17;

  typedef struct {
    logic [DW-1:0]   d;
    logic [TAGW-1:0] t;
    int              cyc;
    bit              lat;
  } ent_t;

  logic            clk = 1'b0;
  logic            rstn;
  logic            i_valid;
  logic [DW-1:0]   i_data;
  logic [TAGW-1:0] i_tag;
  logic            o_ready;

  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   bp_mode = 0;
  int   bp_hold = 0;
  ent_t sb [$];
  int   rd [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fxp_sqrt_stream_if #(.WII(9), .WIF(10), .WOI(9), .WOF(10), .TAGW(4)) bus_a  ();
  fxp_sqrt_stream_if #(.WII(9), .WIF(10), .WOI(9), .WOF(10), .TAGW(4)) bus_r0 ();
  fxp_sqrt_stream_if #(.WII(9), .WIF(10), .WOI(3), .WOF(10), .TAGW(4)) bus_w3 ();

  assign bus_a.i_valid  = i_valid;
  assign bus_a.i_data   = i_data;
  assign bus_a.i_tag    = i_tag;
  assign bus_a.o_ready  = o_ready;
  assign bus_r0.i_valid = i_valid;
  assign bus_r0.i_data  = i_data;
  assign bus_r0.i_tag   = i_tag;
  assign bus_r0.o_ready = o_ready;
  assign bus_w3.i_valid = i_valid;
  assign bus_w3.i_data  = i_data;
  assign bus_w3.i_tag   = i_tag;
  assign bus_w3.o_ready = o_ready;

  fxp_sqrt_stream #(.WII(9), .WIF(10), .WOI(9), .WOF(10), .ROUND(1), .TAGW(4))
    dut_a (.clk(clk), .rstn(rstn), .bus(bus_a));
  fxp_sqrt_stream #(.WII(9), .WIF(10), .WOI(9), .WOF(10), .ROUND(0), .TAGW(4))
    dut_r0 (.clk(clk), .rstn(rstn), .bus(bus_r0));
  fxp_sqrt_stream #(.WII(9), .WIF(10), .WOI(3), .WOF(10), .ROUND(1), .TAGW(4))
    dut_w3 (.clk(clk), .rstn(rstn), .bus(bus_w3));

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: exact integer sqrt of the radicand scaled to 22 fraction bits, then round/saturate.
  function automatic void model(input logic [DW-1:0] d, input bit rnd, input int woi,
                                output longint q, output bit neg, output bit ovf);
    longint a, r, mx;
    neg = d[DW-1];
    ovf = 1'b0;
    q   = 0;
    if (neg) return;
    a = longint'(d) * (longint'(1) << (2 * (WOF + 1) - 10));
    r = longint'($rtoi($sqrt(real'(a))));
    while (r * r > a) r--;
    while ((r + 1) * (r + 1) <= a) r++;
    q  = r / 2 + (rnd ? r % 2 : 0);
    mx = (longint'(1) << (woi + WOF - 1)) - 1;
    if (q > mx) begin
      q   = mx;
      ovf = 1'b1;
    end
  endfunction

  task automatic mon(input int k, input bit rnd, input int woi, input logic v, input logic r,
                     input logic [DW-1:0] d, input logic [TAGW-1:0] t, input logic n, input logic ov);
    longint q;
    bit     en, eo;
    ent_t   e;
    if (v) begin
      check_eq($sformatf("dut%0d.pending", k), 64'(rd[k] < sb.size()), 64'd1);
      if (rd[k] < sb.size()) begin
        e = sb[rd[k]];
        model(e.d, rnd, woi, q, en, eo);
        check_eq($sformatf("dut%0d.%s_data", k, r ? "out" : "stall"), 64'(d), q);
        check_eq($sformatf("dut%0d.%s_tag", k, r ? "out" : "stall"), 64'(t), 64'(e.t));
        if (r) begin
          check_eq($sformatf("dut%0d.neg", k), 64'(n), 64'(en));
          check_eq($sformatf("dut%0d.ovf", k), 64'(ov), 64'(eo));
          if (e.lat) check_eq($sformatf("dut%0d.latency", k), 64'(cyc - e.cyc), 64'(LAT));
          rd[k]++;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      mon(0, 1'b1, 9, bus_a.o_valid,  bus_a.o_ready,  DW'(bus_a.o_data),  bus_a.o_tag,
          bus_a.o_neg,  bus_a.o_overflow);
      mon(1, 1'b0, 9, bus_r0.o_valid, bus_r0.o_ready, DW'(bus_r0.o_data), bus_r0.o_tag,
          bus_r0.o_neg, bus_r0.o_overflow);
      mon(2, 1'b1, 3, bus_w3.o_valid, bus_w3.o_ready, DW'(bus_w3.o_data), bus_w3.o_tag,
          bus_w3.o_neg, bus_w3.o_overflow);
    end
  end

  initial begin : ready_gen
    forever begin
      @(posedge clk);
      #1;
      if (bp_hold > 0) begin
        o_ready = 1'b0;
        bp_hold--;
      end else if (bp_mode == 0) o_ready = 1'b1;
      else if (bp_mode == 1) o_ready = 1'($urandom_range(0, 1));
      else o_ready = 1'b0;
    end
  end

  // Called just after a rising edge; returns just after the edge that took the sample.
  task automatic send(input logic [DW-1:0] d, input logic [TAGW-1:0] t, input bit lat);
    int   waited = 0;
    bit   ok = 1'b0;
    ent_t e;
    i_valid = 1'b1;
    i_data  = d;
    i_tag   = t;
    while (!ok && waited < 200) begin
      @(negedge clk);
      if (rstn && bus_a.i_ready) ok = 1'b1;
      else waited++;
    end
    check_eq("send_accept", 64'(ok), 64'd1);
    if (ok) begin
      e.d = d; e.t = t; e.cyc = cyc; e.lat = lat;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  function automatic bit all_done();
    return rd[0] == sb.size() && rd[1] == sb.size() && rd[2] == sb.size();
  endfunction

  task automatic drain();
    int n = 0;
    while (!all_done() && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain", 64'(all_done()), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [DW-1:0] dir_d [6];
    logic [DW-1:0] d;
    dir_d = '{19'h01000, 19'h00000, 19'h00C00, 19'h7FC00, 19'h06400, 19'h02400};
    rd = '{0, 0, 0};
    rstn = 1'b0; i_valid = 1'b0; i_data = '0; i_tag = '0; o_ready = 1'b1;

    #12;
    check_eq("rst_o_valid", 64'(bus_a.o_valid), 64'd0);
    check_eq("rst_o_data",  64'(bus_a.o_data), 64'd0);
    check_eq("rst_o_tag",   64'(bus_a.o_tag), 64'd0);
    check_eq("rst_o_neg",   64'(bus_a.o_neg), 64'd0);
    check_eq("rst_o_ovf",   64'(bus_a.o_overflow), 64'd0);
    check_eq("rst_i_ready", 64'(bus_a.i_ready), 64'd1);
    check_eq("rst_w3_valid", 64'(bus_w3.o_valid), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Directed values: first one isolated, the rest back to back.
    send(dir_d[0], 4'h1, 1'b1);
    idle(20);
    for (int i = 1; i < 6; i++) send(dir_d[i], TAGW'(i + 9), 1'b1);
    drain();

    // Random stream under pseudo-random backpressure with one 5-cycle stall window.
    bp_mode = 1;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       d = {1'b1, 18'($urandom)};
        1:       d = DW'($urandom_range(0, 4095));
        default: d = {1'b0, 18'($urandom)};
      endcase
      if (i == 12) bp_hold = 5;
      send(d, TAGW'(i % 16), 1'b0);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    bp_mode = 0;
    drain();

    // Fill the pipe while stalled, then reset with ten samples in flight.
    bp_mode = 2;
    idle(2);
    for (int i = 0; i < 10; i++) send(DW'($urandom_range(0, 262143)), TAGW'(i), 1'b0);
    idle(12);
    @(negedge clk);
    check_eq("pre_rst_valid", 64'(bus_a.o_valid), 64'd1);
    #2;
    rstn = 1'b0;
    #1;
    check_eq("midrst_o_valid", 64'(bus_a.o_valid), 64'd0);
    check_eq("midrst_o_data",  64'(bus_a.o_data), 64'd0);
    check_eq("midrst_o_tag",   64'(bus_a.o_tag), 64'd0);
    check_eq("midrst_i_ready", 64'(bus_a.i_ready), 64'd1);
    for (int k = 0; k < 3; k++) rd[k] = sb.size();
    bp_mode = 0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) send(DW'($urandom_range(0, 262143)), TAGW'(i + 11), 1'b1);
    drain();
    idle(5);
    check_eq("final_empty", 64'(all_done()), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
